host_output_multi_schedule: RTL and testbench
=============================================

# host_output_multi_schedule

Parametrised host-port descriptor scheduler between the TS descriptor source, NTS_Q non-TS descriptor FIFOs and the host transmit path. TS descriptors are always served first, except when a configurable burst guard forces one NTS grant. NTS queues are arbitrated by strict priority or weighted round-robin (WRR). One descriptor is issued per host-port free indication.

## Interface
Parameters:
- DESC_W, 13, descriptor (bufid) width
- NTS_Q, 4, number of non-TS FIFOs (1..8)
- WEIGHT_W, 4, WRR weight width per queue
- NTS_MODE, 0, 0 = strict priority (queue 0 highest); 1 = WRR
- TS_BURST_MAX, 0, consecutive TS grants allowed while any NTS queue is non-empty; 0 disables the guard

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- iv_ts_descriptor  in  DESC_W  TS descriptor, valid while i_ts_descriptor_wr=1
- i_ts_descriptor_wr  in  1  TS request level; held until acknowledged
- o_ts_descriptor_scheduled  out  1  one-cycle TS acknowledge
- iv_nts_descriptor  in  NTS_Q*DESC_W  FWFT FIFO heads; queue q at bits [q*DESC_W +: DESC_W]
- iv_fifo_empty  in  NTS_Q  per-queue empty flag
- ov_nts_descriptor_rd  out  NTS_Q  one-hot pop, one cycle
- iv_wrr_weight  in  NTS_Q*WEIGHT_W  per-queue weight; 0 is treated as 1
- i_host_outport_free  in  1  host port may accept the next descriptor
- ov_descriptor  out  DESC_W  issued descriptor
- o_descriptor_wr  out  1  ov_descriptor valid, one cycle
- ov_sched_state  out  2  FSM state, for debug
- ov_debug_ts_cnt  out  16  TS grants, wraps
- ov_debug_nts_cnt  out  NTS_Q*16  per-queue NTS grants, wraps

## Operation
- FSM states: IDLE(0), ARB(1), GET(2). Encoding 3 is illegal and returns to IDLE with all strobes low.
- IDLE: all strobes low, ov_descriptor=0. Moves to ARB if i_host_outport_free=1 or init_flag=1. init_flag is set at reset and cleared on the first IDLE cycle, which guarantees the first pass after reset.
- ARB evaluation order:
  1. force_nts = (TS_BURST_MAX≠0) and ts_burst ≥ TS_BURST_MAX and some queue is non-empty. If force_nts, grant an NTS queue.
  2. Else, if i_ts_descriptor_wr: ov_descriptor=iv_ts_descriptor, o_descriptor_wr=1, o_ts_descriptor_scheduled=1, go to IDLE.
  3. Else, if some queue is non-empty: grant an NTS queue.
  4. Else stay in ARB with outputs low.
- NTS grant in ARB: assert ov_nts_descriptor_rd[q] and latch q; go to GET.
- GET: clear rd; ov_descriptor = head of the latched q; o_descriptor_wr=1; go to IDLE.
- ts_burst counter:
  - +1 on each TS grant, saturating.
  - Cleared on any NTS grant.
  - Cleared on any ARB cycle in which all queues are empty.
- Strict mode: lowest-index non-empty queue wins. rr_ptr and used stay 0.
- WRR mode: starting at rr_ptr, the first non-empty queue q, searching upward with wrap, wins. On a grant:
  - used' = (q==rr_ptr) ? used+1 : 1.
  - If used' ≥ w(q): rr_ptr ← (q+1) mod NTS_Q and used ← 0.
  - Else: rr_ptr ← q and used ← used'.
  - Weights are sampled at grant time.
- Debug counters increment on o_ts_descriptor_scheduled and on ov_nts_descriptor_rd[q] respectively.

## Timing
- Reset values: every output is 0, state=IDLE, init_flag=1, rr_ptr=0, used=0, ts_burst=0.
- TS path: request sampled in ARB at edge E0. o_descriptor_wr and o_ts_descriptor_scheduled are high E0–E1. Minimum TS-to-TS spacing is 2 cycles.
- NTS path: rd high E0–E1. ov_descriptor and o_descriptor_wr are high E1–E2. The FIFO pops at E1. Minimum spacing is 3 cycles.
- A TS request that arrives during GET waits for the next ARB.
- Simultaneous TS and NTS in ARB: TS wins unless force_nts is set.
- Reset mid-GET: the pop may already have occurred. The descriptor is dropped; this is accepted.
- If a queue goes empty between ARB and GET, FIFO underflow is the upstream's responsibility. No check is made here.

## Structure
- Package host_sched_pkg holds:
  - the state encodings IDLE_S, ARB_S, GET_S;
  - the NTS_MODE constants NTS_STRICT and NTS_WRR;
  - a function eff_weight(w) that returns 1 when w is 0, else w.
- Sub-module host_nts_wrr_arbiter:
  - Combinational winner search from rr_ptr; also covers strict mode.
  - Holds the rr_ptr and used registers, updated on a grant strobe.
  - Outputs the one-hot grant and the binary index.
- Top level holds the FSM, ts_burst and the debug counters.

## Test plan
- Reset release, no traffic: FSM enters ARB without i_host_outport_free; outputs stay 0; o_ts_descriptor_scheduled stays 0.
- TS 13'h0A5 and queue 1 head 13'h011 present together, guard off: TS issued first (wr at E0+1); after a free pulse, queue 1 popped and 13'h011 issued 2 cycles after ARB.
- Strict, NTS_Q=4, queues 2 and 3 non-empty: queue 2 drained first; rd pattern 4'b0100 repeats until empty, then 4'b1000.
- WRR, weights {1,2,0,3}, all queues full: grant sequence q0, q1, q1, q2, q3, q3, q3, q0…
- TS_BURST_MAX=2, TS held continuously, queue 0 non-empty: sequence TS, TS, NTS(q0), TS, TS, NTS…; with queue 0 empty, TS is granted continuously.
- i_rst_n asserted during GET: all outputs 0 asynchronously; after release, init pass occurs, rr_ptr=0, counters=0.

Source files
------------

// File: rtl/host_sched_pkg.sv
// Shared types and helpers for the host-port descriptor scheduler.
package host_sched_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    ARB_S  = 2'd1,
    GET_S  = 2'd2
  } sched_state_e;

  localparam int unsigned NTS_STRICT   = 0;
  localparam int unsigned NTS_WRR      = 1;
  localparam int unsigned EFF_WEIGHT_W = 16;

  // A programmed weight of zero still earns one grant per round.
  function automatic logic [EFF_WEIGHT_W-1:0] eff_weight(input logic [EFF_WEIGHT_W-1:0] w);
    return (w == '0) ? EFF_WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/host_nts_wrr_arbiter.sv
// NTS queue arbiter: strict priority or weighted round-robin winner search.
module host_nts_wrr_arbiter
  import host_sched_pkg::*;
#(
  parameter int unsigned NTS_Q    = 4,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned NTS_MODE = 0,
  localparam int unsigned IDX_W   = (NTS_Q > 1) ? $clog2(NTS_Q) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NTS_Q-1:0]          fifo_empty,
  input  logic [NTS_Q*WEIGHT_W-1:0] wrr_weight,
  input  logic                      grant_en,
  output logic                      any_req_c,
  output logic [NTS_Q-1:0]          grant_c,
  output logic [IDX_W-1:0]          grant_idx_c
);

  localparam int unsigned USED_W = WEIGHT_W + 1;

  logic [IDX_W-1:0]        rr_ptr;
  logic [WEIGHT_W-1:0]     used;
  logic [WEIGHT_W-1:0]     w_sel_c;
  logic [EFF_WEIGHT_W-1:0] w_eff_c;
  logic [USED_W-1:0]       used_nxt_c;
  logic [IDX_W-1:0]        ptr_inc_c;
  logic                    wrap_c;
  int unsigned             pos;

  // First non-empty queue searching upward from rr_ptr with wrap.
  always_comb begin
    any_req_c   = 1'b0;
    grant_c     = '0;
    grant_idx_c = '0;
    pos         = 0;
    for (int unsigned i = 0; i < NTS_Q; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NTS_Q) pos = pos - NTS_Q;
      if (!any_req_c && !fifo_empty[IDX_W'(pos)]) begin
        any_req_c   = 1'b1;
        grant_idx_c = IDX_W'(pos);
      end
    end
    grant_c[grant_idx_c] = any_req_c;
  end

  // Weight of the winner and the resulting credit / pointer update.
  always_comb begin
    w_sel_c = '0;
    for (int unsigned q = 0; q < NTS_Q; q++) begin
      if (grant_idx_c == IDX_W'(q)) w_sel_c = wrr_weight[q*WEIGHT_W +: WEIGHT_W];
    end
    w_eff_c    = eff_weight(EFF_WEIGHT_W'(w_sel_c));
    used_nxt_c = (grant_idx_c == rr_ptr) ? ({1'b0, used} + USED_W'(1)) : USED_W'(1);
    wrap_c     = 32'(used_nxt_c) >= 32'(w_eff_c);
    ptr_inc_c  = (32'(grant_idx_c) == NTS_Q - 1) ? '0 : grant_idx_c + IDX_W'(1);
  end

  // Round-robin state; frozen at zero in strict mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
      used   <= '0;
    end else if (grant_en && any_req_c && (NTS_MODE == NTS_WRR)) begin
      if (wrap_c) begin
        rr_ptr <= ptr_inc_c;
        used   <= '0;
      end else begin
        rr_ptr <= grant_idx_c;
        used   <= used_nxt_c[WEIGHT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/host_output_multi_schedule.sv
// Host-port descriptor scheduler: TS first, burst guard, NTS via arbiter.
module host_output_multi_schedule
  import host_sched_pkg::*;
#(
  parameter int unsigned DESC_W       = 13,
  parameter int unsigned NTS_Q        = 4,
  parameter int unsigned WEIGHT_W     = 4,
  parameter int unsigned NTS_MODE     = 0,
  parameter int unsigned TS_BURST_MAX = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DESC_W-1:0]         iv_ts_descriptor,
  input  logic                      i_ts_descriptor_wr,
  output logic                      o_ts_descriptor_scheduled,
  input  logic [NTS_Q*DESC_W-1:0]   iv_nts_descriptor,
  input  logic [NTS_Q-1:0]          iv_fifo_empty,
  output logic [NTS_Q-1:0]          ov_nts_descriptor_rd,
  input  logic [NTS_Q*WEIGHT_W-1:0] iv_wrr_weight,
  input  logic                      i_host_outport_free,
  output logic [DESC_W-1:0]         ov_descriptor,
  output logic                      o_descriptor_wr,
  output logic [1:0]                ov_sched_state,
  output logic [15:0]               ov_debug_ts_cnt,
  output logic [NTS_Q*16-1:0]       ov_debug_nts_cnt
);

  localparam int unsigned IDX_W   = (NTS_Q > 1) ? $clog2(NTS_Q) : 1;
  localparam int unsigned BURST_W = (TS_BURST_MAX < 2) ? 1 : $clog2(TS_BURST_MAX + 1);

  sched_state_e       state;
  logic               init_flag;
  logic [BURST_W-1:0] ts_burst;
  logic [IDX_W-1:0]   get_q;
  logic               any_req_c;
  logic [NTS_Q-1:0]   grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               force_nts_c;
  logic               nts_grant_c;
  logic [DESC_W-1:0]  head_c;

  assign ov_sched_state = state;

  // Burst guard and NTS grant decision for the current ARB cycle.
  assign force_nts_c = (TS_BURST_MAX != 0) && (32'(ts_burst) >= TS_BURST_MAX) && any_req_c;
  assign nts_grant_c = (state == ARB_S) && any_req_c && (force_nts_c || !i_ts_descriptor_wr);

  host_nts_wrr_arbiter #(
    .NTS_Q    (NTS_Q),
    .WEIGHT_W (WEIGHT_W),
    .NTS_MODE (NTS_MODE)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .fifo_empty  (iv_fifo_empty),
    .wrr_weight  (iv_wrr_weight),
    .grant_en    (nts_grant_c),
    .any_req_c   (any_req_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Head of the queue popped in the preceding ARB cycle.
  always_comb begin
    head_c = '0;
    for (int unsigned q = 0; q < NTS_Q; q++) begin
      if (get_q == IDX_W'(q)) head_c = iv_nts_descriptor[q*DESC_W +: DESC_W];
    end
  end

  // Scheduler FSM with registered strobes and descriptor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                     <= IDLE_S;
      init_flag                 <= 1'b1;
      ts_burst                  <= '0;
      get_q                     <= '0;
      ov_descriptor             <= '0;
      o_descriptor_wr           <= 1'b0;
      o_ts_descriptor_scheduled <= 1'b0;
      ov_nts_descriptor_rd      <= '0;
    end else begin
      o_descriptor_wr           <= 1'b0;
      o_ts_descriptor_scheduled <= 1'b0;
      ov_nts_descriptor_rd      <= '0;
      case (state)
        IDLE_S: begin
          ov_descriptor <= '0;
          init_flag     <= 1'b0;
          if (i_host_outport_free || init_flag) state <= ARB_S;
        end
        ARB_S: begin
          if (!any_req_c) ts_burst <= '0;
          if (nts_grant_c) begin
            ov_nts_descriptor_rd <= grant_c;
            get_q                <= grant_idx_c;
            ts_burst             <= '0;
            state                <= GET_S;
          end else if (i_ts_descriptor_wr) begin
            ov_descriptor             <= iv_ts_descriptor;
            o_descriptor_wr           <= 1'b1;
            o_ts_descriptor_scheduled <= 1'b1;
            state                     <= IDLE_S;
            if (any_req_c && (ts_burst != '1)) ts_burst <= ts_burst + BURST_W'(1);
          end
        end
        GET_S: begin
          ov_descriptor   <= head_c;
          o_descriptor_wr <= 1'b1;
          state           <= IDLE_S;
        end
        default: begin
          ov_descriptor <= '0;
          state         <= IDLE_S;
        end
      endcase
    end
  end

  // Wrapping grant counters for debug visibility.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_debug_ts_cnt  <= '0;
      ov_debug_nts_cnt <= '0;
    end else begin
      if (o_ts_descriptor_scheduled) ov_debug_ts_cnt <= ov_debug_ts_cnt + 16'd1;
      for (int unsigned q = 0; q < NTS_Q; q++) begin
        if (ov_nts_descriptor_rd[q])
          ov_debug_nts_cnt[q*16 +: 16] <= ov_debug_nts_cnt[q*16 +: 16] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_host_output_multi_schedule.sv
// Directed bench: strict (dut 0), WRR (dut 1) and burst-guard (dut 2) instances.
module tb_host_output_multi_schedule;

  localparam int unsigned DESC_W   = 13;
  localparam int unsigned NTS_Q    = 4;
  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned ND       = 3;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [DESC_W-1:0]         ts_desc;
  logic                      ts_wr;
  logic [NTS_Q*DESC_W-1:0]   nts_desc;
  logic [NTS_Q-1:0]          empty;
  logic [NTS_Q*WEIGHT_W-1:0] weight;
  logic                      free;

  logic                ts_sched_a [ND];
  logic [NTS_Q-1:0]    rd_a       [ND];
  logic [DESC_W-1:0]   desc_a     [ND];
  logic                wr_a       [ND];
  logic [1:0]          state_a    [ND];
  logic [15:0]         tscnt_a    [ND];
  logic [NTS_Q*16-1:0] ntscnt_a   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    host_output_multi_schedule #(
      .DESC_W       (DESC_W),
      .NTS_Q        (NTS_Q),
      .WEIGHT_W     (WEIGHT_W),
      .NTS_MODE     ((g == 1) ? 1 : 0),
      .TS_BURST_MAX ((g == 2) ? 2 : 0)
    ) u_dut (
      .i_clk                     (i_clk),
      .i_rst_n                   (i_rst_n),
      .iv_ts_descriptor          (ts_desc),
      .i_ts_descriptor_wr        (ts_wr),
      .o_ts_descriptor_scheduled (ts_sched_a[g]),
      .iv_nts_descriptor         (nts_desc),
      .iv_fifo_empty             (empty),
      .ov_nts_descriptor_rd      (rd_a[g]),
      .iv_wrr_weight             (weight),
      .i_host_outport_free       (free),
      .ov_descriptor             (desc_a[g]),
      .o_descriptor_wr           (wr_a[g]),
      .ov_sched_state            (state_a[g]),
      .ov_debug_ts_cnt           (tscnt_a[g]),
      .ov_debug_nts_cnt          (ntscnt_a[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int cnt    [NTS_Q];
  int popped [NTS_Q];
  int epop   [NTS_Q];

  typedef struct {
    logic              ts;
    logic [DESC_W-1:0] tsd;
    int                c0, c1, c2, c3;
    logic [DESC_W-1:0] exp_d;
    logic              exp_ts;
    logic [NTS_Q-1:0]  exp_rd;
  } vec_t;

  vec_t vt [6];

  function automatic logic [DESC_W-1:0] head_of(input int q, input int k);
    return DESC_W'(q * 16 + 1 + k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int q = 0; q < NTS_Q; q++) begin
      empty[q] = (cnt[q] == 0);
      nts_desc[q*DESC_W +: DESC_W] = head_of(q, popped[q]);
    end
  endtask

  // One clock; the FIFO model pops whatever the selected DUT strobed.
  task automatic tick();
    logic [NTS_Q-1:0] r;
    r = rd_a[sel];
    @(posedge i_clk);
    #1;
    for (int q = 0; q < NTS_Q; q++) begin
      if (r[q] && cnt[q] > 0) begin
        cnt[q]--;
        popped[q]++;
      end
    end
    drive_fifo();
  endtask

  task automatic apply_reset(input int s);
    sel     = s;
    i_rst_n = 1'b0;
    free    = 1'b0;
    ts_wr   = 1'b0;
    ts_desc = '0;
    for (int q = 0; q < NTS_Q; q++) begin
      cnt[q] = 0; popped[q] = 0; epop[q] = 0;
    end
    drive_fifo();
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic release_reset();
    drive_fifo();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_issue(output logic [DESC_W-1:0] d, output logic is_ts,
                            output logic [NTS_Q-1:0] rdm);
    d = '0; is_ts = 1'b0; rdm = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      rdm |= rd_a[sel];
      if (wr_a[sel]) begin
        d     = desc_a[sel];
        is_ts = ts_sched_a[sel];
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: no descriptor within 12 cycles, one required");
  endtask

  task automatic expect_nts(input string name, input int q);
    logic [DESC_W-1:0] d;
    logic              t;
    logic [NTS_Q-1:0]  r;
    wait_issue(d, t, r);
    chk({name, "_rd"}, r, NTS_Q'(1) << q);
    chk({name, "_desc"}, d, head_of(q, epop[q]));
    chk({name, "_ts"}, t, 1'b0);
    epop[q]++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DESC_W-1:0] d;
    logic              t;
    logic [NTS_Q-1:0]  r;
    logic              any_wr;
    int                seq_q [8];
    logic              seq_ts [10];

    weight = {4'd3, 4'd0, 4'd2, 4'd1};
    vt[0] = '{1'b1, 13'h0A5,  0, 1, 0, 0, 13'h0A5,  1'b1, 4'b0000};
    vt[1] = '{1'b0, 13'h000,  0, 1, 0, 0, 13'h011,  1'b0, 4'b0010};
    vt[2] = '{1'b0, 13'h000,  0, 0, 2, 3, 13'h021,  1'b0, 4'b0100};
    vt[3] = '{1'b0, 13'h000,  1, 1, 1, 1, 13'h001,  1'b0, 4'b0001};
    vt[4] = '{1'b0, 13'h000,  0, 0, 0, 5, 13'h031,  1'b0, 4'b1000};
    vt[5] = '{1'b1, 13'h1FFF, 1, 1, 1, 1, 13'h1FFF, 1'b1, 4'b0000};

    // Reset values and the init pass with no traffic.
    apply_reset(0);
    chk("rst_desc", desc_a[0], 0);
    chk("rst_wr", wr_a[0], 0);
    chk("rst_ts", ts_sched_a[0], 0);
    chk("rst_rd", rd_a[0], 0);
    chk("rst_state", state_a[0], 0);
    chk("rst_tscnt", tscnt_a[0], 0);
    chk("rst_ntscnt", ntscnt_a[0], 0);
    release_reset();
    tick();
    chk("init_arb", state_a[0], 1);
    any_wr = 1'b0;
    repeat (4) begin
      tick();
      any_wr |= wr_a[0] | ts_sched_a[0] | (|rd_a[0]);
    end
    chk("idle_arb_hold", state_a[0], 1);
    chk("idle_no_strobe", any_wr, 0);

    // Single-issue vectors after reset on the strict instance.
    for (int i = 0; i < 6; i++) begin
      apply_reset(0);
      cnt[0] = vt[i].c0; cnt[1] = vt[i].c1; cnt[2] = vt[i].c2; cnt[3] = vt[i].c3;
      ts_wr   = vt[i].ts;
      ts_desc = vt[i].tsd;
      release_reset();
      wait_issue(d, t, r);
      chk($sformatf("vec%0d_desc", i), d, vt[i].exp_d);
      chk($sformatf("vec%0d_ts", i), t, vt[i].exp_ts);
      chk($sformatf("vec%0d_rd", i), r, vt[i].exp_rd);
    end

    // TS and queue 1 together: TS first, then NTS after a free pulse.
    apply_reset(0);
    cnt[1] = 1; ts_wr = 1'b1; ts_desc = 13'h0A5;
    release_reset();
    tick();
    chk("mix_arb", state_a[0], 1);
    tick();
    chk("mix_ts_wr", wr_a[0], 1);
    chk("mix_ts_ack", ts_sched_a[0], 1);
    chk("mix_ts_desc", desc_a[0], 13'h0A5);
    ts_wr = 1'b0;
    tick();
    chk("mix_idle", state_a[0], 0);
    chk("mix_idle_wr", wr_a[0], 0);
    free = 1'b1;
    tick();
    free = 1'b0;
    chk("mix_arb2", state_a[0], 1);
    tick();
    chk("mix_rd", rd_a[0], 4'b0010);
    chk("mix_get", state_a[0], 2);
    tick();
    chk("mix_nts_wr", wr_a[0], 1);
    chk("mix_nts_desc", desc_a[0], 13'h011);
    chk("mix_tscnt", tscnt_a[0], 1);
    chk("mix_ntscnt", ntscnt_a[0], 64'h0000_0001_0000);

    // Strict drain: queue 2 empties before queue 3 is served.
    apply_reset(0);
    cnt[2] = 2; cnt[3] = 3; free = 1'b1;
    release_reset();
    expect_nts("strict0", 2);
    expect_nts("strict1", 2);
    expect_nts("strict2", 3);
    expect_nts("strict3", 3);
    expect_nts("strict4", 3);
    any_wr = 1'b0;
    repeat (6) begin
      tick();
      any_wr |= wr_a[0];
    end
    chk("strict_empty_quiet", any_wr, 0);

    // WRR with weights {1,2,0,3}, all queues backlogged.
    apply_reset(1);
    for (int q = 0; q < NTS_Q; q++) cnt[q] = 20;
    free = 1'b1;
    release_reset();
    seq_q = '{0, 1, 1, 2, 3, 3, 3, 0};
    for (int i = 0; i < 8; i++) expect_nts($sformatf("wrr%0d", i), seq_q[i]);

    // Reset while in GET for queue 1: asynchronous clear, pointer back to 0.
    for (int c = 0; c < 6 && rd_a[1] == '0; c++) tick();
    chk("midget_rd", rd_a[1], 4'b0010);
    i_rst_n = 1'b0;
    #1;
    chk("midget_state", state_a[1], 0);
    chk("midget_rd_clr", rd_a[1], 0);
    chk("midget_wr_clr", wr_a[1], 0);
    chk("midget_ntscnt", ntscnt_a[1], 0);
    chk("midget_tscnt", tscnt_a[1], 0);
    #2;
    i_rst_n = 1'b1;
    tick();
    chk("midget_init_arb", state_a[1], 1);
    expect_nts("midget_after", 0);

    // Burst guard of 2 with TS held: every third grant goes to queue 0.
    apply_reset(2);
    cnt[0] = 50; ts_wr = 1'b1; ts_desc = 13'h0A5; free = 1'b1;
    release_reset();
    seq_ts = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        cnt[0] = 0;
        drive_fifo();
      end
      wait_issue(d, t, r);
      chk($sformatf("burst%0d_ts", i), t, seq_ts[i]);
      if (seq_ts[i]) begin
        chk($sformatf("burst%0d_desc", i), d, 13'h0A5);
      end else begin
        chk($sformatf("burst%0d_desc", i), d, head_of(0, epop[0]));
        epop[0]++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
